// File: rtl/serial_cascade_comparator.sv
// Slice-serial unsigned magnitude comparator: LSB-first slices drive a registered gt/lt/eq cascade.
// Optional macro CASCADE_SEED_EN adds seed_gt/seed_lt/seed_eq inputs that seed the cascade on the first beat.
module serial_cascade_comparator #(
    parameter int SLICE_W    = 6,
    parameter int MAX_SLICES = 16,
    parameter int CNT_W      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    // Handshakes: a beat/result transfers on a rising edge where valid && ready;
    // valid is never dropped by the block while its ready partner is low.
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_first,
    input  logic               s_last,
    input  logic [SLICE_W-1:0] s_a,
    input  logic [SLICE_W-1:0] s_b,
`ifdef CASCADE_SEED_EN
    input  logic               seed_gt,
    input  logic               seed_lt,
    input  logic               seed_eq,
`endif
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_gt,
    output logic               m_lt,
    output logic               m_eq,
    output logic [CNT_W-1:0]   m_slices,
    output logic               m_ovf,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               accept, start;
    logic               init_gt, init_lt, init_eq;
    logic               pre_gt, pre_lt, pre_eq;
    logic               cnt_sat;

`ifdef CASCADE_SEED_EN
    // Illegal seed combinations resolve gt > lt > eq; all-zero counts as eq.
    assign init_gt = seed_gt;
    assign init_lt = !seed_gt && seed_lt;
    assign init_eq = (seed_eq || !(seed_gt || seed_lt)) && !seed_gt && !seed_lt;
`else
    assign init_gt = 1'b0;
    assign init_lt = 1'b0;
    assign init_eq = 1'b1;
`endif

    assign s_ready = (state_q != HOLD);
    assign accept  = s_valid && s_ready;
    // Any beat taken in IDLE opens a transaction; s_first in ACCUM restarts it.
    assign start   = accept && ((state_q == IDLE) || s_first);
    assign cnt_sat = (cnt_q == CNT_W'(MAX_SLICES));

    assign pre_gt = start ? init_gt : gt_q;
    assign pre_lt = start ? init_lt : lt_q;
    assign pre_eq = start ? init_eq : eq_q;

    always_comb begin
        state_d = state_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (s_a > s_b) begin
                        gt_d = 1'b1; lt_d = 1'b0; eq_d = 1'b0;
                    end else if (s_a < s_b) begin
                        gt_d = 1'b0; lt_d = 1'b1; eq_d = 1'b0;
                    end else begin
                        gt_d = pre_gt; lt_d = pre_lt; eq_d = pre_eq;
                    end
                    if (start) begin
                        cnt_d = CNT_W'(1);
                        ovf_d = 1'b0;
                    end else if (cnt_sat) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = s_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = IDLE;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign m_valid     = (state_q == HOLD);
    assign m_gt        = gt_q;
    assign m_lt        = lt_q;
    assign m_eq        = eq_q;
    assign m_slices    = cnt_q;
    assign m_ovf       = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_cascade_comparator.sv
// Bench for serial_cascade_comparator: beat driver + whole-operand reference model + result scoreboard.
module tb_serial_cascade_comparator;

    localparam int SW = 6;
    localparam int CW = 5;
    localparam int RW = CW + 4;   // {gt, lt, eq, slices, ovf}

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid, s_ready, s_first, s_last;
    logic [SW-1:0] s_a, s_b;
    logic          m_valid, m_ready, m_gt, m_lt, m_eq, m_ovf;
    logic [CW-1:0] m_slices;
    logic [1:0]    dbg_state;
    logic          sd_gt, sd_lt, sd_eq;

    int errors = 0;
    int checks = 0;
    bit stall  = 1'b0;
    bit seed_fixed = 1'b0;

    logic [RW-1:0] exp_q[$];

    serial_cascade_comparator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_first     (s_first),
        .s_last      (s_last),
        .s_a         (s_a),
        .s_b         (s_b),
`ifdef CASCADE_SEED_EN
        .seed_gt     (sd_gt),
        .seed_lt     (sd_lt),
        .seed_eq     (sd_eq),
`endif
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_gt        (m_gt),
        .m_lt        (m_lt),
        .m_eq        (m_eq),
        .m_slices    (m_slices),
        .m_ovf       (m_ovf),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [RW-1:0] pack_out();
        return {m_gt, m_lt, m_eq, m_slices, m_ovf};
    endfunction

    // ---------------- reference model ----------------
    // Operands are rebuilt as whole integers and compared directly.
    logic [SW-1:0] ma[0:31];
    logic [SW-1:0] mb[0:31];
    int            mcount = 0;
    bit            in_txn = 1'b0;
    logic          ms_gt, ms_lt, ms_eq;

    task automatic model_accept(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                input bit first, input bit last);
        logic [191:0] wa, wb;
        logic         gt, lt, eq;
        int           sl;
        if (!in_txn || first) begin
            mcount = 0;
            ms_gt = sd_gt; ms_lt = sd_lt; ms_eq = sd_eq;
        end
        if (mcount < 32) begin
            ma[mcount] = a;
            mb[mcount] = b;
        end
        mcount++;
        in_txn = 1'b1;
        if (last) begin
            wa = '0;
            wb = '0;
            for (int i = 0; i < mcount && i < 32; i++) begin
                wa[i*SW +: SW] = ma[i];
                wb[i*SW +: SW] = mb[i];
            end
            gt = (wa > wb);
            lt = (wa < wb);
            eq = 1'b0;
            if (wa == wb) begin
`ifdef CASCADE_SEED_EN
                if (ms_gt)      gt = 1'b1;
                else if (ms_lt) lt = 1'b1;
                else            eq = 1'b1;
`else
                eq = 1'b1;
`endif
            end
            sl = (mcount > 16) ? 16 : mcount;
            exp_q.push_back({gt, lt, eq, CW'(sl), (mcount > 16)});
            in_txn = 1'b0;
        end
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [RW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && m_valid) begin
                check("onehot", 16'(m_gt + m_lt + m_eq), 16'd1);
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 16'(pack_out()), 16'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 16'(pack_out()), 16'(e));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks (start/end at posedge + 1) ----------------
    task automatic send_beat(input logic [SW-1:0] a, input logic [SW-1:0] b,
                             input bit first, input bit last, input bit gaps,
                             input bit chk, input logic [RW-1:0] expv);
        bit acc = 1'b0;
        s_valid = 1'b1; s_a = a; s_b = b; s_first = first; s_last = last;
        if (!seed_fixed) begin
            sd_gt = 1'($urandom_range(0, 1));
            sd_lt = 1'($urandom_range(0, 1));
            sd_eq = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            check("beat_accept_timeout", 16'd0, 16'd1);
        end else begin
            model_accept(a, b, first, last);
            if (last) begin
                check("latency_m_valid", 16'(m_valid), 16'd1);
                if (chk) check("directed_result", 16'(pack_out()), 16'(expv));
            end
        end
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            done = (!m_valid && exp_q.size() == 0);
        end
        if (!done) check("drain_timeout", 16'd0, 16'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        logic [RW-1:0] held;
        int n;
        logic [SW-1:0] ra, rb;
        rst_n = 1'b0; s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
        s_a = '0; s_b = '0; sd_gt = 1'b0; sd_lt = 1'b0; sd_eq = 1'b1;
        #3;
        check("reset_outputs", 16'({m_valid, m_gt, m_lt, m_eq, m_slices, m_ovf, s_ready}), 16'h001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Higher slice equal: LSB slice decides.
        send_beat(6'd63, 6'd0, 1, 0, 0, 0, '0);
        send_beat(6'd5,  6'd5, 0, 1, 0, 1, {3'b100, 5'd2, 1'b0});
        wait_drain();
        // Higher slice overrides LSB result.
        send_beat(6'd0, 6'd63, 1, 0, 1, 0, '0);
        send_beat(6'd9, 6'd8,  0, 1, 0, 1, {3'b100, 5'd2, 1'b0});
        wait_drain();
        // Stall: result held with m_ready low, pending beat refused.
        stall = 1'b1;
        send_beat(6'd12, 6'd12, 1, 0, 0, 0, '0);
        send_beat(6'd0,  6'd0,  0, 0, 0, 0, '0);
        send_beat(6'd45, 6'd45, 0, 1, 0, 1, {3'b001, 5'd3, 1'b0});
        held = pack_out();
        s_valid = 1'b1; s_first = 1'b1; s_last = 1'b1; s_a = 6'd1; s_b = 6'd2;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid_ready", 16'({m_valid, s_ready}), 16'b10);
            check("stall_stable", 16'(pack_out()), 16'(held));
        end
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1;
        wait_drain();
        // Overflow: 17 beats of (1,2).
        for (int i = 0; i < 17; i++)
            send_beat(6'd1, 6'd2, i == 0, i == 16, 0, i == 16, {3'b010, 5'd16, 1'b1});
        wait_drain();
        check("ovf_cleared", 16'(m_ovf), 16'd0);
        // Restart on s_first mid-transaction.
        send_beat(6'd50, 6'd1, 1, 0, 0, 0, '0);
        send_beat(6'd2,  6'd2, 0, 0, 0, 0, '0);
        send_beat(6'd1,  6'd3, 1, 0, 0, 0, '0);
        send_beat(6'd4,  6'd4, 0, 1, 0, 1, {3'b010, 5'd2, 1'b0});
        wait_drain();
        // Reset mid-ACCUM discards the partial transaction.
        send_beat(6'd10, 6'd20, 1, 0, 0, 0, '0);
        send_beat(6'd30, 6'd30, 0, 0, 0, 0, '0);
        rst_n = 1'b0;
        in_txn = 1'b0;
        #2;
        check("midreset_outputs", 16'({m_valid, m_gt, m_lt, m_eq, m_slices, m_ovf, s_ready}), 16'h001);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // First beat after reset without s_first still starts a transaction.
        send_beat(6'd3, 6'd9, 0, 1, 0, 1, {3'b010, 5'd1, 1'b0});
        wait_drain();
`ifdef CASCADE_SEED_EN
        seed_fixed = 1'b1;
        sd_gt = 1'b0; sd_lt = 1'b1; sd_eq = 1'b0;
        send_beat(6'd7, 6'd7, 1, 1, 0, 1, {3'b010, 5'd1, 1'b0});
        wait_drain();
        seed_fixed = 1'b0;
`endif
        // Randomized transactions, equal-slice bias to exercise the hold path.
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                ra = SW'($urandom_range(0, 63));
                rb = ($urandom_range(0, 2) == 0) ? SW'($urandom_range(0, 63)) : ra;
                if ($urandom_range(0, 3) == 0) rb = SW'($urandom_range(0, 63));
                send_beat(ra, rb, i == 0, i == n - 1, 1, 0, '0);
            end
        end
        wait_drain();
        check("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
